// File: rtl/ctrl_pipe_if.sv
// Bundle between the hazard unit / decode side (master) and the control pipe (slave).
// Carries the decoded word in, stall/flush vectors in, and per-stage words, valids and holds out.
interface ctrl_pipe_if #(
  parameter int W      = 20,
  parameter int NSTAGE = 3
);
  logic [W-1:0]        ctrl_d;
  logic                valid_d;
  logic [NSTAGE-1:0]   stall_i;
  logic [NSTAGE-1:0]   flush_i;
  logic [NSTAGE*W-1:0] ctrl_o;
  logic [NSTAGE-1:0]   valid_o;
  logic [NSTAGE-1:0]   hold_o;
  logic                stall_d_o;
  logic                mc_busy;

  modport master (
    output ctrl_d, valid_d, stall_i, flush_i,
    input  ctrl_o, valid_o, hold_o, stall_d_o, mc_busy
  );

  modport slave (
    input  ctrl_d, valid_d, stall_i, flush_i,
    output ctrl_o, valid_o, hold_o, stall_d_o, mc_busy
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Control-word pipeline E..W with per-stage valid, flush > hold > advance, bubble insertion
// and a multi-cycle hold on stage 0. Define CTRL_PIPE_PERF_EN to add retire/bubble counters.
module ctrl_pipe #(
  parameter int W      = 20,
  parameter int NSTAGE = 3,
  parameter int MC_BIT = 0,
  parameter int MC_LAT = 4,
  parameter int CW     = 8
) (
  input  logic        clk,
  input  logic        rst,
  ctrl_pipe_if.slave  bus
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0] perf_retire,
  output logic [31:0] perf_bubble
`endif
);

  logic [NSTAGE-1:0][W-1:0] w_ctrl;
  logic [NSTAGE-1:0]        w_valid;
  logic [NSTAGE-1:0]        w_hold;
  logic [CW-1:0]            r_cnt;
  logic                     w_mc_busy;

  assign w_mc_busy = (r_cnt != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
      logic [W-1:0] r_ctrl;
      logic         r_valid;
      logic [W-1:0] w_up_ctrl;
      logic         w_up_valid;
      logic         w_up_hold;

      // Hold ripples upstream from the last stage; stage 0 also waits on the multi-cycle counter.
      if (gi == NSTAGE - 1) begin : g_hold_last
        assign w_hold[gi] = bus.stall_i[gi];
      end else if (gi == 0) begin : g_hold_first
        assign w_hold[gi] = bus.stall_i[gi] | w_hold[gi+1] | w_mc_busy;
      end else begin : g_hold_mid
        assign w_hold[gi] = bus.stall_i[gi] | w_hold[gi+1];
      end

      if (gi == 0) begin : g_src_decode
        assign w_up_ctrl  = bus.ctrl_d;
        assign w_up_valid = bus.valid_d;
        assign w_up_hold  = 1'b0;
      end else begin : g_src_stage
        assign w_up_ctrl  = w_ctrl[gi-1];
        assign w_up_valid = w_valid[gi-1];
        assign w_up_hold  = w_hold[gi-1];
      end

      always_ff @(posedge clk) begin
        if (rst || bus.flush_i[gi]) begin
          r_ctrl  <= '0;
          r_valid <= 1'b0;
        end else if (!w_hold[gi]) begin
          // A frozen upstream stage must not be copied, or its word would appear twice.
          if (w_up_hold) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
          end else begin
            r_ctrl  <= w_up_ctrl;
            r_valid <= w_up_valid;
          end
        end
      end

      assign w_ctrl[gi]  = r_ctrl;
      assign w_valid[gi] = r_valid;
    end
  endgenerate

  // Counter runs regardless of external stalls so they overlap the op latency.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i[0]) begin
      r_cnt <= '0;
    end else if (!w_hold[0] && bus.valid_d && bus.ctrl_d[MC_BIT]) begin
      r_cnt <= CW'(MC_LAT - 1);
    end else if (w_mc_busy) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign bus.ctrl_o    = w_ctrl;
  assign bus.valid_o   = w_valid;
  assign bus.hold_o    = w_hold;
  assign bus.stall_d_o = w_hold[0];
  assign bus.mc_busy   = w_mc_busy;

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] r_perf_retire;
  logic [31:0] r_perf_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_retire <= '0;
      r_perf_bubble <= '0;
    end else begin
      if (w_valid[NSTAGE-1] && !w_hold[NSTAGE-1]) begin
        r_perf_retire <= r_perf_retire + 32'd1;
      end
      if (!w_valid[0]) begin
        r_perf_bubble <= r_perf_bubble + 32'd1;
      end
    end
  end

  assign perf_retire = r_perf_retire;
  assign perf_bubble = r_perf_bubble;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Table-driven bench for ctrl_pipe (W=20, NSTAGE=3, MC_BIT=0, MC_LAT=4) with an in-order
// retire scoreboard; control words use an even low nibble unless they are meant to be multi-cycle.
module tb_ctrl_pipe;
  localparam int W  = 20;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_pipe_if #(.W(W), .NSTAGE(NS)) bus ();

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] perf_retire;
  logic [31:0] perf_bubble;
`endif

  ctrl_pipe #(.W(W), .NSTAGE(NS), .MC_BIT(0), .MC_LAT(4), .CW(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .perf_retire(perf_retire),
    .perf_bubble(perf_bubble)
`endif
  );

  typedef struct {
    logic [NS-1:0] stall;
    logic [NS-1:0] flush;
    logic          vd;
    logic [W-1:0]  d;
    logic [W-1:0]  kill;   // word removed from the pipe by this row's flush
    logic [NS-1:0] hold;   // expected hold_o before the edge
    logic [NS-1:0] v;      // expected valid_o after the edge
    logic [W-1:0]  e0, e1, e2;
    logic          mc;     // expected mc_busy after the edge
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] sb_q[$];
  logic [NS-1:0] prev_v;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [NS-1:0] stall, input logic [NS-1:0] flush, input logic vd,
                     input logic [W-1:0] d, input logic [W-1:0] kill, input logic [NS-1:0] hold,
                     input logic [NS-1:0] v, input logic [W-1:0] e0, input logic [W-1:0] e1,
                     input logic [W-1:0] e2, input logic mc);
    vec_t t;
    t.stall = stall; t.flush = flush; t.vd = vd; t.d = d; t.kill = kill;
    t.hold = hold; t.v = v; t.e0 = e0; t.e1 = e1; t.e2 = e2; t.mc = mc;
    vecs.push_back(t);
  endtask

  task automatic run_vec(input int idx, input vec_t t);
    int kidx;
    logic [W-1:0] exp_w;
    @(negedge clk);
    bus.stall_i = t.stall;
    bus.flush_i = t.flush;
    bus.valid_d = t.vd;
    bus.ctrl_d  = t.d;
    #1;
    chk($sformatf("v%0d hold_o", idx), 64'(bus.hold_o), 64'(t.hold));
    chk($sformatf("v%0d stall_d_o", idx), 64'(bus.stall_d_o), 64'(t.hold[0]));
    // The last stage retires this edge: it must be the oldest word still owed.
    if (prev_v[NS-1] && !t.hold[NS-1] && !t.flush[NS-1]) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL v%0d retire: got %0h, required nothing in flight", idx, bus.ctrl_o[(NS-1)*W +: W]);
      end else begin
        exp_w = sb_q.pop_front();
        chk($sformatf("v%0d retire", idx), 64'(bus.ctrl_o[(NS-1)*W +: W]), 64'(exp_w));
      end
    end
    if (t.kill != '0) begin
      kidx = -1;
      foreach (sb_q[i]) if (sb_q[i] == t.kill) kidx = i;
      if (kidx < 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL v%0d kill: got no in-flight word, required %0h", idx, t.kill);
      end else begin
        sb_q.delete(kidx);
      end
    end
    if (t.vd && !t.hold[0] && !t.flush[0]) sb_q.push_back(t.d);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d valid_o", idx), 64'(bus.valid_o), 64'(t.v));
    chk($sformatf("v%0d ctrl_o", idx), 64'(bus.ctrl_o), 64'({t.e2, t.e1, t.e0}));
    chk($sformatf("v%0d mc_busy", idx), 64'(bus.mc_busy), 64'(t.mc));
    prev_v = t.v;
    $display("[TB] vec %0d stall=%b flush=%b vd=%b d=%05h -> valid=%b s0=%05h s1=%05h s2=%05h mc=%b",
             idx, t.stall, t.flush, t.vd, t.d, bus.valid_o, bus.ctrl_o[0 +: W],
             bus.ctrl_o[W +: W], bus.ctrl_o[2*W +: W], bus.mc_busy);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, " valid_o"}, 64'(bus.valid_o), 64'(0));
    chk({tag, " ctrl_o"}, 64'(bus.ctrl_o), 64'(0));
    chk({tag, " mc_busy"}, 64'(bus.mc_busy), 64'(0));
    chk({tag, " hold_o"}, 64'(bus.hold_o), 64'(0));
`ifdef CTRL_PIPE_PERF_EN
    chk({tag, " perf_retire"}, 64'(perf_retire), 64'(0));
    chk({tag, " perf_bubble"}, 64'(perf_bubble), 64'(0));
`endif
  endtask

  initial begin
    // stall flush vd  d      kill   hold    valid   s0     s1     s2     mc
    add(3'b000, 3'b000, 1, 'h12, 0,    3'b000, 3'b001, 'h12,  0,     0,     0); // stream fill
    add(3'b000, 3'b000, 1, 'h22, 0,    3'b000, 3'b011, 'h22,  'h12,  0,     0);
    add(3'b000, 3'b000, 1, 'h32, 0,    3'b000, 3'b111, 'h32,  'h22,  'h12,  0);
    add(3'b010, 3'b000, 1, 'h42, 0,    3'b011, 3'b011, 'h32,  'h22,  0,     0); // mid stall
    add(3'b010, 3'b000, 1, 'h42, 0,    3'b011, 3'b011, 'h32,  'h22,  0,     0);
    add(3'b000, 3'b000, 1, 'h42, 0,    3'b000, 3'b111, 'h42,  'h32,  'h22,  0);
    add(3'b000, 3'b000, 1, 'h01, 0,    3'b000, 3'b111, 'h01,  'h42,  'h32,  1); // multi-cycle load
    add(3'b000, 3'b000, 1, 'h52, 0,    3'b001, 3'b101, 'h01,  0,     'h42,  1);
    add(3'b000, 3'b000, 1, 'h52, 0,    3'b001, 3'b001, 'h01,  0,     0,     1);
    add(3'b000, 3'b000, 1, 'h52, 0,    3'b001, 3'b001, 'h01,  0,     0,     0);
    add(3'b000, 3'b000, 1, 'h52, 0,    3'b000, 3'b011, 'h52,  'h01,  0,     0);
    add(3'b000, 3'b000, 0, 'h00, 0,    3'b000, 3'b110, 0,     'h52,  'h01,  0); // drain
    add(3'b000, 3'b000, 0, 'h00, 0,    3'b000, 3'b100, 0,     0,     'h52,  0);
    add(3'b000, 3'b000, 0, 'h00, 0,    3'b000, 3'b000, 0,     0,     0,     0);
    add(3'b000, 3'b000, 1, 'h61, 0,    3'b000, 3'b001, 'h61,  0,     0,     1); // mc then flush
    add(3'b000, 3'b000, 1, 'h72, 0,    3'b001, 3'b001, 'h61,  0,     0,     1);
    add(3'b000, 3'b001, 1, 'h72, 'h61, 3'b001, 3'b000, 0,     0,     0,     0);
    add(3'b000, 3'b000, 1, 'h72, 0,    3'b000, 3'b001, 'h72,  0,     0,     0);
    add(3'b000, 3'b000, 1, 'h82, 0,    3'b000, 3'b011, 'h82,  'h72,  0,     0);
    add(3'b000, 3'b000, 1, 'h92, 0,    3'b000, 3'b111, 'h92,  'h82,  'h72,  0);
    add(3'b010, 3'b010, 1, 'hA2, 'h82, 3'b011, 3'b001, 'h92,  0,     0,     0); // flush+stall stage 1
    add(3'b000, 3'b000, 1, 'hA2, 0,    3'b000, 3'b011, 'hA2,  'h92,  0,     0);
    add(3'b000, 3'b000, 0, 'h00, 0,    3'b000, 3'b110, 0,     'hA2,  'h92,  0);
    add(3'b111, 3'b000, 1, 'hB2, 0,    3'b111, 3'b110, 0,     'hA2,  'h92,  0); // all stall
    add(3'b000, 3'b000, 1, 'hC2, 0,    3'b000, 3'b101, 'hC2,  0,     'hA2,  0);
    add(3'b000, 3'b000, 1, 'hD2, 0,    3'b000, 3'b011, 'hD2,  'hC2,  0,     0);
    add(3'b000, 3'b000, 1, 'hE3, 0,    3'b000, 3'b111, 'hE3,  'hD2,  'hC2,  1); // full pipe, mc busy

    rst         = 1'b1;
    bus.stall_i = '0;
    bus.flush_i = '0;
    bus.valid_d = 1'b0;
    bus.ctrl_d  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("reset");
    @(negedge clk);
    rst    = 1'b0;
    prev_v = '0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    chk("scoreboard in-flight", 64'(sb_q.size()), 64'(3));

    // Reset in the middle of a multi-cycle op with every stage occupied.
    @(negedge clk);
    rst         = 1'b1;
    bus.valid_d = 1'b1;
    bus.ctrl_d  = 'hF3;
    @(posedge clk);
    #1;
    chk_cleared("mid-op reset");
    sb_q.delete();
    $display("[TB] reset mid multi-cycle op -> valid=%b mc=%b", bus.valid_o, bus.mc_busy);

    @(negedge clk);
    rst         = 1'b0;
    bus.valid_d = 1'b0;
    bus.ctrl_d  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle valid_o", 64'(bus.valid_o), 64'(0));
`ifdef CTRL_PIPE_PERF_EN
    chk("idle perf_bubble", 64'(perf_bubble), 64'(2));
    chk("idle perf_retire", 64'(perf_retire), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
